fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 9-bit-instruction / 8-bit-datapath pipeline. Owns the PC,
//  drives instruction-memory address, and presents if_instruction to the IF/ID pipe register.
//  Consumes the branch/jump feedback the IF/ID pipe returns (if_branch_*, if_jump_*), and
//  redirects the PC and raises flush toward the IF/ID pipe on a taken redirect.
//  Holds on hazard stall; enters a sticky HALT state on the halt opcode.
// PARAMETERS
//  RESET_PC     8'h00    PC value loaded on reset
//  HALT_OPCODE  9'h1FF   instruction word that halts fetch
//  NOP_WORD     9'h000   word driven on if_instruction while halted
// PORTS
//  clock            in   1   single clock, all state updates on rising edge
//  reset            in   1   synchronous, active-high
//  stall            in   1   hazard stall: hold PC and fetch counter
//  imem_addr        out  8   instruction memory address (= pc, combinational)
//  imem_data        in   9   instruction memory read data (combinational ROM)
//  if_instruction   out  9   fetched word to IF/ID pipe
//  if_pc            out  8   PC of word on if_instruction (= pc)
//  if_branch_ctrl   in   1   branch taken
//  if_branch_value  in   8   signed two's-complement branch offset
//  if_jump_ctrl     in   1   jump taken
//  if_jump_value    in   8   absolute jump target
//  flush            out  1   to IF/ID pipe: squash the word being fetched
//  halted           out  1   1 while in HALT state
//  fetch_count      out  16  count of words accepted into the pipe, saturating
// BEHAVIOUR
//  Interface: one clock (clock); reset is synchronous and active-high (reset).
//  Reset (rising edge with reset=1): pc<=RESET_PC, state<=RUN, fetch_count<=0. While reset is
//   high: flush=0, halted=0, if_instruction=imem_data. Reset mid-HALT returns to RUN.
//  Control inputs: only exactly 1'b1 is taken; 0, X or Z = not taken (the IF/ID pipe drives X
//   after its flush). Compare with ===1'b1.
//  States: RUN, HALT. halted = (state==HALT).
//  RUN next-PC priority, evaluated each rising edge:
//   1. jump_ctrl          -> pc <= if_jump_value
//   2. else branch_ctrl   -> pc <= pc + sext(if_branch_value), mod 256 (wraps both ways)
//   3. else stall         -> pc holds
//   4. else imem_data==HALT_OPCODE -> pc holds, state <= HALT
//   5. else               -> pc <= pc + 1, 8'hFF wraps to 8'h00
//   Redirect overrides stall. Redirect also cancels halt detection that cycle.
//  flush (combinational) = state==RUN && !reset && (jump_ctrl||branch_ctrl).
//   Asserted exactly in the cycle(s) the redirect input is high. Never asserted in HALT.
//  if_instruction = (state==HALT) ? NOP_WORD : imem_data. The halt word itself is presented
//   for one accepting cycle before HALT.
//  HALT: pc, fetch_count frozen; redirect and stall inputs ignored; exit only via reset.
//  fetch_count: +1 on each RUN edge with no redirect and no stall (cases 4 and 5). Halt word
//   counts once. Saturates at 16'hFFFF (no wrap).
//  Latency: redirect input -> imem_addr = target on the next cycle (one edge).
// TESTING
//  Reset, no stall, imem all 9'h001 -> imem_addr 00,01,02,...; 8'hFF->8'h00 wrap;
//   fetch_count = edges since reset.
//  pc=8'h10, branch_ctrl=1 with value 8'hFC -> flush=1 that cycle; next pc=8'h0C. With
//   value 8'h7F at pc=8'hF0 -> next pc=8'h6F.
//  jump_ctrl=1 (value 8'h40) and branch_ctrl=1 (value 8'h05) together, stall=1 -> next pc=8'h40;
//   flush=1; fetch_count unchanged.
//  stall=1 for 3 cycles at pc=8'h22 -> pc stays 8'h22, count frozen; release -> 8'h23.
//   branch/jump ctrl = X -> treated as not taken, flush=0.
//  imem_data=HALT_OPCODE at pc=8'h05 -> halt word out once, count+1; then halted=1,
//   if_instruction=NOP_WORD, pc=8'h05 despite jump_ctrl=1; reset -> pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port plus the IF/ID pipe exchange
// (fetched word out, branch/jump feedback in, flush out).
interface fetch_if;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [8:0] if_instruction;
  logic [7:0] if_pc;
  logic       if_branch_ctrl;
  logic [7:0] if_branch_value;
  logic       if_jump_ctrl;
  logic [7:0] if_jump_value;
  logic       flush;

  // master = fetch stage, slave = memory + IF/ID pipe side
  modport master (
    output imem_addr,
    input  imem_data,
    output if_instruction,
    output if_pc,
    input  if_branch_ctrl,
    input  if_branch_value,
    input  if_jump_ctrl,
    input  if_jump_value,
    output flush
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_instruction,
    input  if_pc,
    output if_branch_ctrl,
    output if_branch_value,
    output if_jump_ctrl,
    output if_jump_value,
    input  flush
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, applies jump/branch redirects,
// holds on stall and enters a sticky HALT on the halt opcode.
module fetch_stage #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [8:0] HALT_OPCODE = 9'h1FF,
  parameter logic [8:0] NOP_WORD    = 9'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  fetch_if.master     bus,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pc;
  logic [7:0]  w_pc_next;
  logic [15:0] r_fetch_count;
  logic [15:0] w_fetch_count_next;

  logic w_jump;
  logic w_branch;
  logic w_stall;
  logic w_run;
  logic w_halt_word;
  logic [15:0] w_count_inc;

  // The IF/ID pipe drives X after a flush; only a clean 1 counts as taken.
  assign w_jump      = (bus.if_jump_ctrl === 1'b1);
  assign w_branch    = (bus.if_branch_ctrl === 1'b1);
  assign w_stall     = (stall === 1'b1);
  assign w_run       = (r_state == ST_RUN);
  assign w_halt_word = (bus.imem_data == HALT_OPCODE);
  assign w_count_inc = (r_fetch_count == 16'hFFFF) ? r_fetch_count
                                                    : r_fetch_count + 16'd1;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_fetch_count_next = r_fetch_count;
    case (r_state)
      ST_RUN: begin
        if (w_jump) begin
          w_pc_next = bus.if_jump_value;
        end else if (w_branch) begin
          // 8-bit add of the two's-complement offset wraps both ways
          w_pc_next = r_pc + bus.if_branch_value;
        end else if (w_stall) begin
          w_pc_next = r_pc;
        end else if (w_halt_word) begin
          w_state_next       = ST_HALT;
          w_fetch_count_next = w_count_inc;
        end else begin
          w_pc_next          = r_pc + 8'd1;
          w_fetch_count_next = w_count_inc;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_fetch_count <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  // Reset forces the RUN-side view even before the reset edge lands.
  assign bus.imem_addr      = r_pc;
  assign bus.if_pc          = r_pc;
  assign halted             = !w_run && !reset;
  assign bus.if_instruction = halted ? NOP_WORD : bus.imem_data;
  assign bus.flush          = w_run && !reset && (w_jump || w_branch);
  assign fetch_count        = r_fetch_count;

endmodule
